// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver: initiator for the HLS ap_ctrl_hs block-level handshake.
// Launches cmd_count transactions with up to MAX_OUT in flight.
// Ports: ap_clk/ap_rst_n, cmd_valid/cmd_ready/cmd_count (run request),
//   child_ap_start/child_ap_ready/child_ap_done (child handshake),
//   busy, lat_valid/lat_cycles/lat_index (per transaction),
//   run_done/total_cycles (per run), err/err_code/err_clr (errors).
module ap_ctrl_driver #(
  parameter int CNT_W   = 32,
  parameter int N_W     = 16,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N_W-1:0]   cmd_count,
  output logic             child_ap_start,
  input  logic             child_ap_ready,
  input  logic             child_ap_done,
  output logic             busy,
  output logic             lat_valid,
  output logic [CNT_W-1:0] lat_cycles,
  output logic [N_W-1:0]   lat_index,
  output logic             run_done,
  output logic [CNT_W-1:0] total_cycles,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] ONE_C = 1;
  localparam logic [N_W-1:0]   ONE_N = 1;
  localparam logic [PW-1:0]    ONE_P = 1;

  typedef enum logic [1:0] {
    S_IDLE, S_LAUNCH, S_DRAIN, S_ERR
  } state_t;

  state_t           r_state;
  logic             r_cmd_rdy;
  logic [CNT_W-1:0] r_tstamp;
  logic [CNT_W-1:0] r_t0;
  logic [N_W-1:0]   r_rem;
  logic [N_W-1:0]   r_cnt;
  logic [N_W-1:0]   r_cmpl;
  logic [OW-1:0]    r_out;
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CNT_W-1:0] r_mem [2**PW];
  logic [CNT_W-1:0] r_wd;
  logic             r_start;
  logic             r_lat_v;
  logic [CNT_W-1:0] r_lat_c;
  logic [N_W-1:0]   r_lat_i;
  logic             r_run_done;
  logic [CNT_W-1:0] r_total;
  logic             r_err;
  logic [1:0]       r_ecode;

  logic             w_acc;
  logic             w_dn;
  logic             w_live;
  logic             w_active;
  logic             w_cmd;
  logic             w_spur;
  logic             w_byp;
  logic             w_push;
  logic             w_pop;
  logic             w_cmp;
  logic             w_last;
  logic             w_trip;
  logic [CNT_W-1:0] w_wd_inc;
  logic [CNT_W-1:0] w_lat;
  logic [N_W-1:0]   w_rem_nx;
  logic [OW-1:0]    w_out_nx;
  logic             w_start_nx;
  state_t           w_st_nx;
  logic [1:0]       w_ecode;

  assign w_acc    = r_start & child_ap_ready;
  assign w_dn     = child_ap_done;
  assign w_live   = (r_state != S_ERR);
  assign w_active = (r_state == S_LAUNCH) | (r_state == S_DRAIN);
  assign w_cmd    = cmd_valid & r_cmd_rdy;

  // Done with nothing in flight: either bypass (same-cycle accept)
  // or a protocol violation.
  assign w_spur = w_live & w_dn & (r_out == '0) & ~w_acc;
  assign w_byp  = w_live & w_dn & (r_out == '0) & w_acc;
  assign w_push = w_acc & ~w_byp;
  assign w_pop  = w_live & w_dn & (r_out != '0);
  assign w_cmp  = w_pop | w_byp;
  assign w_last = w_cmp & ((r_cmpl + ONE_N) == r_cnt);
  assign w_lat  = w_byp ? '0 : (r_tstamp - r_mem[r_rd]);

  // r_wd restarts at 1 so err shows TIMEOUT cycles after the last event.
  assign w_wd_inc = r_wd + ONE_C;
  assign w_trip   = w_active & ~w_acc & ~w_dn
                  & (w_wd_inc >= CNT_W'(TIMEOUT));

  assign w_rem_nx = (r_state == S_IDLE) ? cmd_count
                  : (r_rem - N_W'(w_acc));
  assign w_out_nx = r_out + OW'(w_push) - OW'(w_pop);

  always_comb begin
    w_st_nx = r_state;
    w_ecode = 2'd0;
    unique case (r_state)
      S_IDLE: begin
        if (w_spur) begin
          w_st_nx = S_ERR;
          w_ecode = 2'd1;
        end else if (w_cmd && cmd_count != '0) begin
          w_st_nx = S_LAUNCH;
        end
      end
      S_LAUNCH, S_DRAIN: begin
        if (w_spur) begin
          w_st_nx = S_ERR;
          w_ecode = 2'd1;
        end else if (w_last) begin
          w_st_nx = S_IDLE;
        end else if (w_trip) begin
          w_st_nx = S_ERR;
          w_ecode = 2'd2;
        end else if (r_state == S_LAUNCH
                     && w_acc && r_rem == ONE_N) begin
          w_st_nx = S_DRAIN;
        end
      end
      S_ERR: begin
        if (err_clr) w_st_nx = S_IDLE;
      end
      default: w_st_nx = S_IDLE;
    endcase
  end

  // A raised start holds until accepted; a new one needs room in flight.
  assign w_start_nx = (w_st_nx == S_LAUNCH)
    & ((r_start & ~w_acc)
       | ((w_rem_nx != '0) & (w_out_nx < OW'(MAX_OUT))));

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_cmd_rdy  <= 1'b0;
      r_tstamp   <= '0;
      r_t0       <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_cmpl     <= '0;
      r_out      <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_wd       <= ONE_C;
      r_start    <= 1'b0;
      r_lat_v    <= 1'b0;
      r_lat_c    <= '0;
      r_lat_i    <= '0;
      r_run_done <= 1'b0;
      r_total    <= '0;
      r_err      <= 1'b0;
      r_ecode    <= 2'd0;
    end else begin
      r_state   <= w_st_nx;
      r_cmd_rdy <= (w_st_nx == S_IDLE);
      r_tstamp  <= r_tstamp + ONE_C;
      r_start   <= w_start_nx;

      if (r_state == S_IDLE && w_cmd) begin
        r_t0   <= r_tstamp;
        r_cnt  <= cmd_count;
        r_cmpl <= '0;
      end else if (w_cmp) begin
        r_cmpl <= r_cmpl + ONE_N;
      end

      if ((r_state == S_IDLE && w_cmd) || w_acc)
        r_rem <= w_rem_nx;

      if (r_state == S_ERR && err_clr) begin
        r_out <= '0;
        r_wr  <= '0;
        r_rd  <= '0;
      end else if (w_live) begin
        r_out <= w_out_nx;
        if (w_push) r_wr <= r_wr + ONE_P;
        if (w_pop)  r_rd <= r_rd + ONE_P;
      end

      if (w_active && !(w_acc || w_dn))
        r_wd <= w_wd_inc;
      else
        r_wd <= ONE_C;

      r_lat_v <= w_cmp;
      if (w_cmp) begin
        r_lat_c <= w_lat;
        r_lat_i <= r_cmpl;
      end

      r_run_done <= 1'b0;
      if (r_state == S_IDLE && w_cmd
          && cmd_count == '0 && !w_spur) begin
        r_run_done <= 1'b1;
        r_total    <= '0;
      end else if (w_last && !w_spur) begin
        r_run_done <= 1'b1;
        r_total    <= r_tstamp - r_t0;
      end

      if (r_state == S_ERR && err_clr) begin
        r_err   <= 1'b0;
        r_ecode <= 2'd0;
      end else if (r_state != S_ERR && w_st_nx == S_ERR) begin
        r_err   <= 1'b1;
        r_ecode <= w_ecode;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_live && w_push) r_mem[r_wr] <= r_tstamp;
  end

  assign cmd_ready      = r_cmd_rdy;
  assign child_ap_start = r_start;
  assign busy           = w_active;
  assign lat_valid      = r_lat_v;
  assign lat_cycles     = r_lat_c;
  assign lat_index      = r_lat_i;
  assign run_done       = r_run_done;
  assign total_cycles   = r_total;
  assign err            = r_err;
  assign err_code       = r_ecode;

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// tb_ap_ctrl_driver: scoreboard bench for ap_ctrl_driver.
// Behavioural child model pushes expected latencies on each accept.
module tb_ap_ctrl_driver;
  localparam int CW = 32;
  localparam int NW = 16;
  localparam int MO = 4;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [NW-1:0] cmd_count;
  logic          start, ready, done;
  logic          busy, lat_valid, run_done, err, err_clr;
  logic [CW-1:0] lat_cycles, total_cycles;
  logic [NW-1:0] lat_index;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  ap_ctrl_driver #(
    .CNT_W(CW), .N_W(NW), .MAX_OUT(MO), .TIMEOUT(TO)
  ) dut (
    .ap_clk        (clk),
    .ap_rst_n      (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_count     (cmd_count),
    .child_ap_start(start),
    .child_ap_ready(ready),
    .child_ap_done (done),
    .busy          (busy),
    .lat_valid     (lat_valid),
    .lat_cycles    (lat_cycles),
    .lat_index     (lat_index),
    .run_done      (run_done),
    .total_cycles  (total_cycles),
    .err           (err),
    .err_code      (err_code),
    .err_clr       (err_clr)
  );

  typedef struct {
    int idx;
    int lat;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   q_due[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  int c_lat = 5, c_rd = 0, exp_n = 0, t_cmd = 0;
  bit c_pipe = 0, c_comb = 0, c_never = 0;
  bit inj = 0, clr_req = 0;

  bit c_busy = 0, c_ready = 0, c_done = 0;
  int c_wait = 0, idx = 0, outst = 0, max_out = 0;
  int hold_len = 0, last_acc = 0, last_done = 0;
  int n_runs = 0, err_cyc = 0;
  bit err_seen = 0, prev_acc = 0, post_acc_start = 0;

  assign ready = c_ready;
  assign done  = c_done;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc++;

  // Child model and output monitor; cycle k is sampled at its negedge.
  always @(negedge clk) begin
    bit   dn, rdy, acc;
    exp_t e;
    if (!rst_n || clr_req) begin
      sb.delete();
      q_due.delete();
      c_busy   = 0;
      c_wait   = 0;
      c_ready  = 0;
      c_done   = 0;
      outst    = 0;
      err_seen = 0;
      prev_acc = 0;
    end else begin
      if (lat_valid) begin
        if (sb.size() == 0) begin
          chk("lat_unexpected", 64'(lat_index), 64'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("lat_cycles", 64'(lat_cycles), 64'(e.lat));
          chk("lat_index", 64'(lat_index), 64'(e.idx));
          chk("run_done_on_last", 64'(run_done), 64'(e.last));
        end
      end
      if (run_done) begin
        n_runs++;
        if (exp_n == 0) begin
          chk("run_done_cyc", 64'(cyc), 64'(t_cmd + 1));
          chk("total_cycles", 64'(total_cycles), 64'd0);
        end else begin
          chk("run_done_cyc", 64'(cyc), 64'(last_done + 1));
          chk("total_cycles", 64'(total_cycles),
              64'(last_done - t_cmd));
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);
      end
      if (err && !err_seen) begin
        err_seen = 1;
        err_cyc  = cyc;
      end
      if (cmd_valid && cmd_ready) idx = 0;

      if (prev_acc) post_acc_start = start;

      dn = 0;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
        void'(q_due.pop_front());
        dn     = 1;
        c_busy = 0;
      end
      if (c_comb)
        rdy = start;
      else
        rdy = start && (c_wait >= c_rd) && (c_pipe || !c_busy);
      acc = start && rdy;
      if (acc) begin
        hold_len = c_wait + 1;
        c_wait   = 0;
        last_acc = cyc;
        if (!c_never)
          sb.push_back('{idx, c_comb ? 0 : c_lat, idx == exp_n - 1});
        idx++;
        if (c_comb) dn = 1;
        else if (!c_never) q_due.push_back(cyc + c_lat);
        if (!c_pipe) c_busy = 1;
      end else if (start) begin
        c_wait++;
      end
      if (dn) last_done = cyc;
      outst = outst + int'(acc) - int'(dn);
      if (outst > max_out) max_out = outst;
      prev_acc = acc;
      c_ready  = rdy;
      c_done   = dn || inj;
    end
  end

  task automatic cfg(input int lat, input int rd,
                     input bit pipe, input bit comb,
                     input bit never);
    c_lat   = lat;
    c_rd    = rd;
    c_pipe  = pipe;
    c_comb  = comb;
    c_never = never;
  endtask

  task automatic cmd(input int n);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_count = NW'(n);
    t_cmd     = cyc;
    exp_n     = n;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run(input int n);
    int n0;
    n0 = n_runs;
    cmd(n);
    for (int i = 0; i < 400 && n_runs == n0; i++)
      @(posedge clk);
    #1;
    chk("run_finished", 64'(n_runs), 64'(n0 + 1));
  endtask

  task automatic clear_err();
    @(posedge clk); #1;
    clr_req = 1'b1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    err_clr = 1'b0;
    @(posedge clk); #1;
    chk("clr_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("clr_err", 64'({err, err_code}), 64'd0);
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_count = '0;
    err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("idle_outs", 64'({busy, lat_valid, run_done, err,
                          err_code, lat_cycles, total_cycles}), 64'd0);

    cfg(5, 0, 0, 0, 0);
    run(3);

    cfg(10, 0, 1, 0, 0);
    run(8);
    chk("max_outstanding", 64'(max_out), 64'(MO));

    cfg(2, 3, 1, 0, 0);
    run(1);
    chk("start_hold_len", 64'(hold_len), 64'd4);
    chk("start_drop", 64'(post_acc_start), 64'd0);

    cfg(0, 0, 1, 1, 0);
    run(2);

    run(0);

    cfg(5, 10, 1, 0, 0);
    cmd(1);
    @(posedge clk); #1;
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    chk("spur_err", 64'(err), 64'd1);
    chk("spur_code", 64'(err_code), 64'd1);
    chk("spur_start", 64'(start), 64'd0);
    chk("spur_busy", 64'(busy), 64'd0);
    chk("spur_cmd_ready", 64'(cmd_ready), 64'd0);
    clear_err();

    cfg(5, 0, 1, 0, 1);
    cmd(2);
    for (int i = 0; i < 60 && !err_seen; i++)
      @(posedge clk);
    #1;
    chk("wd_seen", 64'(err_seen), 64'd1);
    chk("wd_cycle", 64'(err_cyc), 64'(last_acc + TO));
    chk("wd_code", 64'(err_code), 64'd2);
    clear_err();

    cfg(10, 0, 1, 0, 0);
    cmd(8);
    repeat (14) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_lat", 64'(lat_cycles), 64'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_start", 64'(start), 64'd0);
    chk("arst_ctl", 64'({cmd_ready, busy, lat_valid, run_done,
                         err, err_code}), 64'd0);
    chk("arst_lat", 64'(lat_cycles), 64'd0);
    chk("arst_idx", 64'(lat_index), 64'd0);
    chk("arst_total", 64'(total_cycles), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    cfg(5, 0, 0, 0, 0);
    run(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
